// File: rtl/milano_prefetch_buffer.sv
// ============================================================================
// milano_prefetch_buffer
// ----------------------------------------------------------------------------
// Instruction-fetch front end for the milano core.  It issues word fetches on
// a req/gnt/rvalid instruction bus, keeps up to MAX_OUTSTANDING granted
// transactions in flight and buffers returned words together with their PC in
// a DEPTH-entry FIFO that feeds the ID stage.  A jump/branch redirect from EX
// empties the FIFO, squashes every word still in flight and restarts fetching
// at the jump target.
//
// Parameters
//   DEPTH            FIFO entries (power of two, >= 2)
//   MAX_OUTSTANDING  granted-but-not-returned bus transactions (1..DEPTH)
//
// Ports
//   clk_i            core clock
//   rst_ni           asynchronous active-low reset
//   boot_addr_i      fetch address loaded on the first clock after reset
//   fetch_enable_i   0 stops new requests; in-flight requests still complete
//   jump_flag_i      redirect pulse from EX
//   jump_addr_i      redirect target (bits [1:0] ignored)
//   instr_req_o      bus request
//   instr_addr_o     bus word address
//   instr_gnt_i      bus grant
//   instr_rvalid_i   read data valid (in order, one per grant)
//   instr_rdata_i    read data
//   instr_valid_o    head of FIFO valid toward ID
//   instr_ready_i    ID accepts the head
//   instr_rdata_o    head instruction word
//   instr_addr_o_id  head instruction address (PC)
//
// Build option
//   MILANO_PF_BYPASS_EN  when defined, a returning word that finds the FIFO
//                        empty (and is not being squashed) is presented to ID
//                        in the same cycle; it is only written into the FIFO
//                        if ID does not take it.  When undefined, everything
//                        toward ID comes from the FIFO registers.
// ============================================================================
module milano_prefetch_buffer #(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] boot_addr_i,
    input  logic        fetch_enable_i,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_rdata_o,
    output logic [31:0] instr_addr_o_id
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int SW = ((CW > OW) ? CW : OW) + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic          booted;
    logic [31:0]   fetch_pc;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] discard;

    logic [31:0]   fifo_data [DEPTH];
    logic [31:0]   fifo_addr [DEPTH];
    logic [PW-1:0] fifo_rd_ptr;
    logic [PW-1:0] fifo_wr_ptr;
    logic [CW-1:0] fifo_count;

    // Addresses of granted transactions, oldest first.  Its occupancy is
    // exactly 'outstanding', so it needs no count of its own.  Squashed
    // transactions stay in it and retire normally when their data returns.
    logic [31:0]   addr_q [MAX_OUTSTANDING];
    logic [AW-1:0] addr_q_rd;
    logic [AW-1:0] addr_q_wr;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic          fifo_empty;
    logic [SW-1:0] occupancy;
    logic          grant;
    logic          ret;
    logic          drop;
    logic          deliver;
    logic          bypass_take;
    logic          push;
    logic          pop;
    logic [OW-1:0] outstanding_next;
    logic [AW-1:0] addr_q_rd_inc;
    logic [AW-1:0] addr_q_wr_inc;
    logic          unused_addr_lsbs;

    assign unused_addr_lsbs = ^{boot_addr_i[1:0], jump_addr_i[1:0]};

    assign fifo_empty = (fifo_count == '0);
    // Slots already spoken for: words in the FIFO plus words still on the
    // bus.  Gating requests on this keeps the FIFO from ever overflowing.
    assign occupancy  = SW'(outstanding) + SW'(fifo_count);

    assign instr_req_o  = fetch_enable_i & booted
                        & (outstanding < OW'(MAX_OUTSTANDING))
                        & (occupancy < SW'(DEPTH));
    assign instr_addr_o = fetch_pc;

    assign grant = instr_req_o & instr_gnt_i;
    // An rvalid with nothing in flight cannot belong to us (e.g. a stale
    // response straddling reset) and is ignored.
    assign ret   = instr_rvalid_i & (outstanding != '0);

    // Words returning in a redirect cycle or owed to an earlier redirect are
    // thrown away.
    assign drop    = ret & (jump_flag_i | (discard != '0));
    assign deliver = ret & ~drop;

    always_comb begin
        outstanding_next = outstanding;
        case ({grant, ret})
            2'b10:   outstanding_next = outstanding + 1'b1;
            2'b01:   outstanding_next = outstanding - 1'b1;
            default: outstanding_next = outstanding;
        endcase
    end

    assign addr_q_rd_inc = (addr_q_rd == AW'(MAX_OUTSTANDING - 1)) ? '0 : addr_q_rd + 1'b1;
    assign addr_q_wr_inc = (addr_q_wr == AW'(MAX_OUTSTANDING - 1)) ? '0 : addr_q_wr + 1'b1;

    // ------------------------------------------------------------------
    // Output toward ID
    // ------------------------------------------------------------------
`ifdef MILANO_PF_BYPASS_EN
    logic bypass_hit;

    // deliver already implies no redirect and nothing owed to discard.
    assign bypass_hit  = deliver & fifo_empty;
    assign bypass_take = bypass_hit & instr_ready_i;

    assign instr_valid_o   = ~fifo_empty | bypass_hit;
    assign instr_rdata_o   = bypass_hit ? instr_rdata_i     : fifo_data[fifo_rd_ptr];
    assign instr_addr_o_id = bypass_hit ? addr_q[addr_q_rd] : fifo_addr[fifo_rd_ptr];
`else
    assign bypass_take = 1'b0;

    assign instr_valid_o   = ~fifo_empty;
    assign instr_rdata_o   = fifo_data[fifo_rd_ptr];
    assign instr_addr_o_id = fifo_addr[fifo_rd_ptr];
`endif

    assign push = deliver & ~bypass_take;
    // A pop in the redirect cycle is meaningless: the FIFO is being cleared.
    assign pop  = ~fifo_empty & instr_ready_i & ~jump_flag_i;

    // ------------------------------------------------------------------
    // Fetch PC, bus bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            booted      <= 1'b0;
            fetch_pc    <= '0;
            outstanding <= '0;
            discard     <= '0;
            addr_q_rd   <= '0;
            addr_q_wr   <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            // Boot load takes precedence; no request can be pending then.
            if (!booted) begin
                booted   <= 1'b1;
                fetch_pc <= {boot_addr_i[31:2], 2'b00};
            end else if (jump_flag_i) begin
                fetch_pc <= {jump_addr_i[31:2], 2'b00};
            end else if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
            end

            outstanding <= outstanding_next;

            // Every transaction still on the bus after this edge, including
            // one granted in the redirect cycle, belongs to the old stream.
            if (jump_flag_i) begin
                discard <= outstanding_next;
            end else if (ret && (discard != '0)) begin
                discard <= discard - 1'b1;
            end

            if (grant) begin
                addr_q[addr_q_wr] <= fetch_pc;
                addr_q_wr         <= addr_q_wr_inc;
            end
            if (ret) begin
                addr_q_rd <= addr_q_rd_inc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Word FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_rd_ptr <= '0;
            fifo_wr_ptr <= '0;
            fifo_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_addr[i] <= '0;
            end
        end else if (jump_flag_i) begin
            fifo_rd_ptr <= '0;
            fifo_wr_ptr <= '0;
            fifo_count  <= '0;
        end else begin
            if (push) begin
                fifo_data[fifo_wr_ptr] <= instr_rdata_i;
                fifo_addr[fifo_wr_ptr] <= addr_q[addr_q_rd];
                fifo_wr_ptr            <= fifo_wr_ptr + 1'b1;
            end
            if (pop) begin
                fifo_rd_ptr <= fifo_rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule
